// File: rtl/shift_in_ctrl.sv
// ============================================================================
// shift_in_ctrl : read-side controller for an external 8-bit PISO shift
//                 register (PL/CE/CP/Q7). Optional macro: SHIFT_IN_AUTO_EN.
// Revision 1.0
// ============================================================================
`default_nettype none

module shift_in_ctrl #(
    parameter int WIDTH = 8,
    parameter int DIV   = 2
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
`ifdef SHIFT_IN_AUTO_EN
    input  logic             Auto,
`endif
    input  logic             Q7,
    output logic             PL,
    output logic             CE,
    output logic             CP,
    output logic [WIDTH-1:0] Data,
    output logic             Valid,
    output logic             Busy
);

    localparam int DCW = $clog2(DIV + 1);
    localparam int BCW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_LOAD     = 2'd1,
        S_SHIFT_LO = 2'd2,
        S_SHIFT_HI = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [DCW-1:0]     div_q, div_d;
    logic [BCW-1:0]     bit_q, bit_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               pl_q, pl_d;
    logic               ce_q, ce_d;
    logic               cp_q, cp_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;

    logic               w_go;
    logic               w_phase_end;
    logic               w_last_bit;
    logic [WIDTH-1:0]   w_shreg_next;

`ifdef SHIFT_IN_AUTO_EN
    assign w_go = Start | Auto;
`else
    assign w_go = Start;
`endif

    assign w_phase_end  = (div_q == DCW'(DIV - 1));
    assign w_last_bit   = (bit_q == BCW'(WIDTH - 1));
    assign w_shreg_next = {shreg_q[WIDTH-2:0], Q7};

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            pl_q    <= 1'b1;
            ce_q    <= 1'b1;
            cp_q    <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            pl_q    <= pl_d;
            ce_q    <= ce_d;
            cp_q    <= cp_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    // Output registers are loaded with the value for the state being entered,
    // so every pin changes on the same edge as the state transition.
    always_comb begin
        state_d = state_q;
        div_d   = div_q + DCW'(1);
        bit_d   = bit_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        pl_d    = pl_q;
        ce_d    = ce_q;
        cp_d    = cp_q;
        valid_d = 1'b0;
        busy_d  = busy_q;

        case (state_q)
            S_IDLE: begin
                div_d  = '0;
                bit_d  = '0;
                pl_d   = 1'b1;
                ce_d   = 1'b1;
                cp_d   = 1'b0;
                busy_d = 1'b0;
                if (w_go) begin
                    state_d = S_LOAD;
                    pl_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            S_LOAD: begin
                if (w_phase_end) begin
                    state_d = S_SHIFT_LO;
                    div_d   = '0;
                    bit_d   = '0;
                    pl_d    = 1'b1;
                    ce_d    = 1'b0;
                end
            end
            S_SHIFT_LO: begin
                if (w_phase_end) begin
                    div_d   = '0;
                    shreg_d = w_shreg_next;
                    bit_d   = bit_q + BCW'(1);
                    if (w_last_bit) begin
                        state_d = S_IDLE;
                        bit_d   = '0;
                        data_d  = w_shreg_next;
                        valid_d = 1'b1;
                        ce_d    = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = S_SHIFT_HI;
                        cp_d    = 1'b1;
                    end
                end
            end
            S_SHIFT_HI: begin
                if (w_phase_end) begin
                    state_d = S_SHIFT_LO;
                    div_d   = '0;
                    cp_d    = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                div_d   = '0;
                bit_d   = '0;
            end
        endcase
    end

    assign PL    = pl_q;
    assign CE    = ce_q;
    assign CP    = cp_q;
    assign Data  = data_q;
    assign Valid = valid_q;
    assign Busy  = busy_q;

endmodule

`default_nettype wire
